uart_rx_ctrl: RTL and testbench

- UART receive controller for the host command link. Oversampling is not used.
- Detects the start bit on the serial line and raises bps_start to run the baud tick generator.
- Samples each bit on the generator's mid-bit clk_bps pulse and presents the received byte with a one-cycle valid strobe.
- Sits between the rs232 pin and the command parser, directly upstream of and paired with the baud generator.

---
 rtl/uart_rx_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
//
// UART receive controller for the host command link. It has no oversampling.
// A falling edge on the synchronized serial line starts a frame. While the
// frame is in progress, bps_start asks the paired baud generator for mid-bit
// clk_bps ticks. Each tick samples one bit: the start bit, DATA_BITS data bits
// (LSB first), then a single stop bit. There is no parity bit. A frame whose
// stop bit samples high updates rx_data and produces a one-cycle rx_valid. A
// frame whose stop bit samples low produces a one-cycle rx_frame_err and leaves
// rx_data untouched.
//
// Ports
//   sys_clk       in   1          system clock
//   sys_rstn      in   1          asynchronous active-low reset
//   rs232_rx      in   1          raw asynchronous serial line, idle high
//   clk_bps       in   1          one-cycle mid-bit tick from the baud generator
//   bps_start     out  1          run request to the baud generator (whole frame)
//   rx_data       out  DATA_BITS  last correctly framed byte
//   rx_valid      out  1          one-cycle pulse when rx_data updates
//   rx_frame_err  out  1          one-cycle pulse when the stop bit samples low
//   rx_busy       out  1          high while a frame is being received
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int DATA_BITS = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_rstn,
    input  logic                 rs232_rx,
    input  logic                 clk_bps,
    output logic                 bps_start,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Line conditioning: two synchronizer stages plus one stage for edge detect.
    logic rx_sync1_r;
    logic rx_sync2_r;
    logic rx_sync3_r;
    logic rx_bit_s;
    logic fall_s;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [CNT_W-1:0]     bit_cnt_r;
    logic [CNT_W-1:0]     bit_cnt_nxt_s;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_nxt_s;
    logic [DATA_BITS-1:0] data_r;
    logic [DATA_BITS-1:0] data_nxt_s;
    logic                 bps_start_r;
    logic                 bps_start_nxt_s;
    logic                 valid_r;
    logic                 valid_nxt_s;
    logic                 err_r;
    logic                 err_nxt_s;
    logic                 busy_r;
    logic                 busy_nxt_s;

    // The synchronizer stages reset to the idle (high) level. This keeps reset
    // release from looking like a start edge.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            rx_sync1_r <= 1'b1;
            rx_sync2_r <= 1'b1;
            rx_sync3_r <= 1'b1;
        end else begin
            rx_sync1_r <= rs232_rx;
            rx_sync2_r <= rx_sync1_r;
            rx_sync3_r <= rx_sync2_r;
        end
    end

    // Bits are sampled from the second stage. Only a high-to-low transition
    // counts as a start. A line held low, such as a break, never re-triggers.
    assign rx_bit_s = rx_sync2_r;
    assign fall_s   = rx_sync3_r & ~rx_sync2_r;

    // Frame state register, the datapath registers and the registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= {CNT_W{1'b0}};
            shift_r     <= {DATA_BITS{1'b0}};
            data_r      <= {DATA_BITS{1'b0}};
            bps_start_r <= 1'b0;
            valid_r     <= 1'b0;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            bit_cnt_r   <= bit_cnt_nxt_s;
            shift_r     <= shift_nxt_s;
            data_r      <= data_nxt_s;
            bps_start_r <= bps_start_nxt_s;
            valid_r     <= valid_nxt_s;
            err_r       <= err_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    // Next-state logic and next-output logic. clk_bps is only acted on outside
    // IDLE. A falling edge is only acted on in IDLE. An edge that arrives while
    // the stop bit is being sampled is therefore dropped.
    always_comb begin
        state_nxt_s     = state_r;
        bit_cnt_nxt_s   = bit_cnt_r;
        shift_nxt_s     = shift_r;
        data_nxt_s      = data_r;
        bps_start_nxt_s = bps_start_r;
        valid_nxt_s     = 1'b0;
        err_nxt_s       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (fall_s) begin
                    state_nxt_s     = ST_START;
                    bps_start_nxt_s = 1'b1;
                end else begin
                    bps_start_nxt_s = 1'b0;
                end
            end

            ST_START: begin
                if (clk_bps) begin
                    if (!rx_bit_s) begin
                        state_nxt_s   = ST_DATA;
                        bit_cnt_nxt_s = {CNT_W{1'b0}};
                    end else begin
                        // The line is back high at mid-start: treat it as a glitch.
                        state_nxt_s     = ST_IDLE;
                        bps_start_nxt_s = 1'b0;
                    end
                end else begin
                    state_nxt_s = ST_START;
                end
            end

            ST_DATA: begin
                if (clk_bps) begin
                    // LSB arrives first, so shifting in at the MSB side leaves
                    // bit 0 in position 0 after the last data bit.
                    shift_nxt_s   = {rx_bit_s, shift_r[DATA_BITS-1:1]};
                    bit_cnt_nxt_s = bit_cnt_r + CNT_W'(1);
                    if (bit_cnt_r == LAST_BIT) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end

            ST_STOP: begin
                if (clk_bps) begin
                    state_nxt_s     = ST_IDLE;
                    bps_start_nxt_s = 1'b0;
                    if (rx_bit_s) begin
                        data_nxt_s  = shift_r;
                        valid_nxt_s = 1'b1;
                    end else begin
                        err_nxt_s   = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end

            default: begin
                state_nxt_s     = ST_IDLE;
                bps_start_nxt_s = 1'b0;
            end
        endcase

        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    assign bps_start    = bps_start_r;
    assign rx_data      = data_r;
    assign rx_valid     = valid_r;
    assign rx_frame_err = err_r;
    assign rx_busy      = busy_r;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
//
// Self-checking bench for uart_rx_ctrl. A small behavioural baud generator
// produces one clk_bps tick per bit period at mid-bit while bps_start is high.
// The bit period is shortened so that the run stays brief.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    localparam int P    = 16;
    localparam int HALF = P / 2;

    logic       sys_clk;
    logic       sys_rstn;
    logic       rs232_rx;
    logic       clk_bps;
    logic       bps_start;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;
    logic       force_bps;

    int checks;
    int failures;

    uart_rx_ctrl #(.DATA_BITS(8)) dut (
        .sys_clk      (sys_clk),
        .sys_rstn     (sys_rstn),
        .rs232_rx     (rs232_rx),
        .clk_bps      (clk_bps),
        .bps_start    (bps_start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Behavioural baud generator: the period restarts whenever bps_start is low.
    int baud_cnt;
    always @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn)            baud_cnt <= 0;
        else if (!bps_start)      baud_cnt <= 0;
        else if (baud_cnt == P-1) baud_cnt <= 0;
        else                      baud_cnt <= baud_cnt + 1;
    end
    assign clk_bps = (bps_start && (baud_cnt == HALF - 1)) || force_bps;

    // Cycle counter and output monitor.
    int cyc;
    int valid_cnt, err_cnt, bps_rise, both_cnt, wide_cnt, last_valid_cyc;
    logic prev_valid, prev_err, prev_bps;
    logic [7:0] data_last, data_prev;

    initial begin
        cyc = 0; valid_cnt = 0; err_cnt = 0; bps_rise = 0; both_cnt = 0;
        wide_cnt = 0; last_valid_cyc = 0; prev_valid = 1'b0; prev_err = 1'b0;
        prev_bps = 1'b0; data_last = 8'h00; data_prev = 8'h00;
    end

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (rx_valid) begin
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cyc;
            data_prev      <= data_last;
            data_last      <= rx_data;
        end
        if (rx_frame_err)                       err_cnt  <= err_cnt + 1;
        if ((rx_valid && prev_valid) || (rx_frame_err && prev_err))
                                                wide_cnt <= wide_cnt + 1;
        if (rx_valid && rx_frame_err)           both_cnt <= both_cnt + 1;
        if (bps_start && !prev_bps)             bps_rise <= bps_rise + 1;
        prev_valid <= rx_valid;
        prev_err   <= rx_frame_err;
        prev_bps   <= bps_start;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one frame. The caller is at a negedge. The line is left at the
    // stop-bit level.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rs232_rx = 1'b0;
        repeat (P) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            rs232_rx = d[i];
            repeat (P) @(negedge sys_clk);
        end
        rs232_rx = stop_bit;
        repeat (P) @(negedge sys_clk);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_valid;
        int         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];
    int v0, e0, r0, t0, lat;

    initial begin
        checks = 0; failures = 0;
        sys_rstn = 1'b0; rs232_rx = 1'b1; force_bps = 1'b0; lat = 0;

        vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
        vecs[1] = '{8'h11, 1'b1, 1, 0, 8'h11};
        vecs[2] = '{8'h3C, 1'b0, 0, 1, 8'h11};
        vecs[3] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[4] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vecs[5] = '{8'h80, 1'b1, 1, 0, 8'h80};

        // Reset state.
        repeat (3) @(negedge sys_clk);
        check("rst_bps_start", bps_start, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_frame_err", rx_frame_err, 0);
        check("rst_rx_busy", rx_busy, 0);
        sys_rstn = 1'b1;
        repeat (4) @(negedge sys_clk);

        // False start: a short low glitch is rejected at the start-bit sample.
        v0 = valid_cnt; e0 = err_cnt; r0 = bps_rise;
        rs232_rx = 1'b0;
        repeat (P/4) @(negedge sys_clk);
        rs232_rx = 1'b1;
        repeat (3*P) @(negedge sys_clk);
        check("glitch_bps_rise", bps_rise - r0, 1);
        check("glitch_valid", valid_cnt - v0, 0);
        check("glitch_err", err_cnt - e0, 0);
        check("glitch_data", rx_data, 8'h00);
        check("glitch_bps_low", bps_start, 0);
        check("glitch_busy", rx_busy, 0);

        // 0xA5 with bps_start latency and valid timing.
        v0 = valid_cnt; e0 = err_cnt; t0 = cyc; lat = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                for (int n = 1; n <= 10 && lat == 0; n++) begin
                    @(posedge sys_clk);
                    #1;
                    if (bps_start) lat = n;
                end
            end
        join
        repeat (2*P) @(negedge sys_clk);
        check("a5_bps_latency", lat, 3);
        check("a5_valid", valid_cnt - v0, 1);
        check("a5_err", err_cnt - e0, 0);
        check("a5_data", rx_data, 8'hA5);
        check("a5_bps_low", bps_start, 0);
        check("a5_valid_time",
              ((last_valid_cyc - t0) >= 9*P && (last_valid_cyc - t0) <= 10*P) ? 1 : 0, 1);

        // Table-driven frames.
        for (int k = 0; k < 6; k++) begin
            v0 = valid_cnt; e0 = err_cnt;
            send_frame(vecs[k].data, vecs[k].stop);
            rs232_rx = 1'b1;
            repeat (2*P) @(negedge sys_clk);
            check($sformatf("vec%0d_valid", k), valid_cnt - v0, vecs[k].exp_valid);
            check($sformatf("vec%0d_err", k), err_cnt - e0, vecs[k].exp_err);
            check($sformatf("vec%0d_data", k), rx_data, vecs[k].exp_data);
            check($sformatf("vec%0d_bps", k), bps_start, 0);
            check($sformatf("vec%0d_busy", k), rx_busy, 0);
        end

        // A good byte, then a frame error followed by a held-low break.
        v0 = valid_cnt; e0 = err_cnt; r0 = bps_rise;
        send_frame(8'h11, 1'b1);
        send_frame(8'h3C, 1'b0);
        repeat (3*P) @(negedge sys_clk);
        check("break_busy_held_low", rx_busy, 0);
        rs232_rx = 1'b1;
        repeat (3*P) @(negedge sys_clk);
        check("break_err", err_cnt - e0, 1);
        check("break_valid", valid_cnt - v0, 1);
        check("break_data", rx_data, 8'h11);
        check("break_bps_rise", bps_rise - r0, 2);

        // Back-to-back frames.
        v0 = valid_cnt; r0 = bps_rise;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (2*P) @(negedge sys_clk);
        check("b2b_valid", valid_cnt - v0, 2);
        check("b2b_first", data_prev, 8'h00);
        check("b2b_second", data_last, 8'hFF);
        check("b2b_bps_rise", bps_rise - r0, 2);

        // Reset during data bit 4 of 0x5A, then a clean 0xC3.
        v0 = valid_cnt; e0 = err_cnt;
        fork
            send_frame(8'h5A, 1'b1);
            begin
                repeat (5*P + HALF) @(negedge sys_clk);
                check("mid_busy_before_rst", rx_busy, 1);
                sys_rstn = 1'b0;
                #1;
                check("mid_rst_bps", bps_start, 0);
                check("mid_rst_data", rx_data, 0);
                check("mid_rst_valid", rx_valid, 0);
                check("mid_rst_err", rx_frame_err, 0);
                check("mid_rst_busy", rx_busy, 0);
            end
        join
        sys_rstn = 1'b1;
        repeat (4) @(negedge sys_clk);
        send_frame(8'hC3, 1'b1);
        repeat (2*P) @(negedge sys_clk);
        check("post_rst_valid", valid_cnt - v0, 1);
        check("post_rst_err", err_cnt - e0, 0);
        check("post_rst_data", rx_data, 8'hC3);

        // Forced clk_bps ticks while idle must not move the controller.
        v0 = valid_cnt; e0 = err_cnt; r0 = bps_rise;
        for (int k = 0; k < 4; k++) begin
            force_bps = 1'b1;
            @(negedge sys_clk);
            force_bps = 1'b0;
            @(negedge sys_clk);
            check($sformatf("idle_tick%0d_busy", k), rx_busy, 0);
        end
        repeat (4) @(negedge sys_clk);
        check("idle_tick_bps_rise", bps_rise - r0, 0);
        check("idle_tick_pulses", (valid_cnt - v0) + (err_cnt - e0), 0);
        check("idle_tick_data", rx_data, 8'hC3);

        // Pulse properties over the whole run.
        check("valid_err_overlap", both_cnt, 0);
        check("pulse_width", wide_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
